// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2,
    MATCH   = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_PAT_4 = 4'b1011;

  // Width needed to count history bits 0..pat_w inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating count of valid bits.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  localparam int unsigned FILL_W = fill_width(PAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              bit_in,
  output logic [PAT_W-1:0]  hist,
  output logic [FILL_W-1:0] fill
);

  // Clearing only drops the fill count; stale history is masked by fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift_en) begin
        hist <= {hist[PAT_W-2:0], bit_in};
      end
      if (clear) begin
        fill <= '0;
      end else if (shift_en && (fill != FILL_W'(PAT_W))) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with registered match flag.
// Optional match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEFAULT_PAT_4),
  parameter int unsigned      CNT_W       = 8,
  localparam int unsigned     FILL_W      = fill_width(PAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  input  logic              overlap_en,
  output logic              y,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [FILL_W-1:0] fill
);

  state_t             state_q;
  state_t             state_d;
  logic [PAT_W-1:0]   pattern;
  logic [PAT_W-1:0]   hist;
  logic               accept_c;
  logic               clear_c;
  logic               match_c;
  logic [PAT_W-1:0]   hist_next_c;
  logic [FILL_W-1:0]  fill_next_c;

  // A pattern load discards any bit offered in the same cycle.
  assign accept_c    = in_valid & ~pat_load;
  assign hist_next_c = {hist[PAT_W-2:0], in};
  assign fill_next_c = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
  assign match_c     = accept_c && (fill_next_c == FILL_W'(PAT_W)) && (hist_next_c == pattern);
  assign clear_c     = pat_load | (match_c & ~overlap_en);

  seq_det_hist #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept_c),
    .clear    (clear_c),
    .bit_in   (in),
    .hist     (hist),
    .fill     (fill)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= DEFAULT_PAT;
    end else if (pat_load) begin
      pattern <= pat_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      y       <= 1'b0;
    end else begin
      state_q <= state_d;
      y       <= (state_d == MATCH);
    end
  end

  // Next state follows the accepted bit; MATCH with no bit falls back by fill.
  always_comb begin
    state_d = state_q;
    if (pat_load) begin
      state_d = EMPTY;
    end else if (accept_c) begin
      if (match_c) begin
        state_d = MATCH;
      end else if (fill_next_c == FILL_W'(PAT_W)) begin
        state_d = ARMED;
      end else begin
        state_d = FILLING;
      end
    end else begin
      case (state_q)
        EMPTY, FILLING, ARMED: state_d = state_q;
        MATCH:                 state_d = (fill == '0) ? EMPTY : ARMED;
        default:               state_d = EMPTY;
      endcase
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (pat_load) begin
      cnt_q <= '0;
    end else if (match_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (honours SEQ_DET_MATCH_CNT_EN).
module tb_seq_detect_param;

  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_bit;
  logic              pat_load;
  logic [PAT_W-1:0]  pat_in;
  logic              overlap_en;
  logic              y;
  logic [CNT_W-1:0]  match_cnt;
  logic [FILL_W-1:0] fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in_bit),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .overlap_en (overlap_en),
    .y          (y),
    .match_cnt  (match_cnt),
    .fill       (fill)
  );

  function automatic int ecnt(input int n);
`ifdef SEQ_DET_MATCH_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [PAT_W-1:0] p);
    pat_load = 1'b1;
    pat_in   = p;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
  endtask

  task automatic run_stream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] yexp);
    for (int i = 0; i < n; i++) begin
      send(bits[n-1-i]);
      chk($sformatf("%s_y%0d", tag, i), 32'(y), 32'(yexp[n-1-i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pv;
    int         e;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    pat_load   = 1'b0;
    pat_in     = '0;
    overlap_en = 1'b0;

    #2;
    chk("reset_y", 32'(y), 0);
    chk("reset_fill", 32'(fill), 0);
    chk("reset_cnt", 32'(match_cnt), 0);
    #10;
    rst = 1'b1;

    // default pattern, non-overlap
    send(1'b1); chk("t1_fill1", 32'(fill), 1); chk("t1_y1", 32'(y), 0);
    send(1'b0); chk("t1_fill2", 32'(fill), 2);
    send(1'b1); chk("t1_fill3", 32'(fill), 3); chk("t1_y3", 32'(y), 0);
    send(1'b1); chk("t1_y4", 32'(y), 1); chk("t1_fill4", 32'(fill), 0);
    chk("t1_cnt", 32'(match_cnt), 32'(ecnt(1)));
    idle(1); chk("t1_y_after", 32'(y), 0); chk("t1_cnt_hold", 32'(match_cnt), 32'(ecnt(1)));

    // overlap stream
    overlap_en = 1'b1;
    load(4'b1011);
    chk("t2_load_fill", 32'(fill), 0); chk("t2_load_cnt", 32'(match_cnt), 0);
    chk("t2_load_y", 32'(y), 0);
    run_stream("t2_ov", 16'b1011011, 7, 16'b0001001);
    chk("t2_ov_cnt", 32'(match_cnt), 32'(ecnt(2)));
    idle(1); chk("t2_ov_idle_y", 32'(y), 0); chk("t2_ov_idle_fill", 32'(fill), 4);

    // same stream, non-overlap
    overlap_en = 1'b0;
    load(4'b1011);
    run_stream("t2_nov", 16'b1011011, 7, 16'b0001000);
    chk("t2_nov_cnt", 32'(match_cnt), 32'(ecnt(1)));
    chk("t2_nov_fill", 32'(fill), 3);

    // in_valid gaps
    load(4'b1011);
    pv = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      send(pv[3-i]);
      chk($sformatf("t3_y_bit%0d", i), 32'(y), (i == 3) ? 1 : 0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          idle(1);
          chk($sformatf("t3_gap_fill%0d_%0d", i, g), 32'(fill), 32'(i + 1));
          chk($sformatf("t3_gap_y%0d_%0d", i, g), 32'(y), 0);
        end
      end
    end
    idle(1); chk("t3_y_after", 32'(y), 0);
    chk("t3_cnt", 32'(match_cnt), 32'(ecnt(1)));

    // pattern load collides with a valid bit
    load(4'b1011);
    send(1'b1); send(1'b0);
    chk("t4_fill_pre", 32'(fill), 2);
    pat_load = 1'b1; pat_in = 4'b0110; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    pat_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    chk("t4_fill_load", 32'(fill), 0); chk("t4_cnt_load", 32'(match_cnt), 0);
    chk("t4_y_load", 32'(y), 0);
    run_stream("t4_new", 16'b0110, 4, 16'b0001);
    chk("t4_cnt", 32'(match_cnt), 32'(ecnt(1)));

    // all-ones pattern with saturation
    overlap_en = 1'b1;
    load(4'b1111);
    for (int i = 1; i <= 300; i++) begin
      send(1'b1);
      e = (i < 4) ? 0 : ((i - 3) > 255 ? 255 : (i - 3));
      chk($sformatf("t5_y%0d", i), 32'(y), (i >= 4) ? 1 : 0);
      chk($sformatf("t5_cnt%0d", i), 32'(match_cnt), 32'(ecnt(e)));
    end
    idle(1); chk("t5_y_idle", 32'(y), 0);

    // asynchronous reset mid-stream restores the default pattern
    overlap_en = 1'b0;
    load(4'b0110);
    run_stream("t6_pre", 16'b0110, 4, 16'b0001);
    send(1'b1); send(1'b0); send(1'b1);
    chk("t6_fill_pre", 32'(fill), 3);
    chk("t6_cnt_pre", 32'(match_cnt), 32'(ecnt(1)));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_y", 32'(y), 0); chk("t6_rst_fill", 32'(fill), 0);
    chk("t6_rst_cnt", 32'(match_cnt), 0);
    #2;
    rst = 1'b1;
    run_stream("t6_post", 16'b1011, 4, 16'b0001);
    chk("t6_post_cnt", 32'(match_cnt), 32'(ecnt(1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
